// File: rtl/deskew_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : deskew_buffer_if
// Description : Lane bus between the systolic array columns and the deskew
//               buffer. Carries the skewed per-lane inputs and the aligned row
//               outputs, including the sticky alignment-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface deskew_buffer_if #(
    parameter int N_SIZE    = 4,
    parameter int DATAWIDTH = 32
);
    logic [N_SIZE-1:0]                valid_in;
    logic [N_SIZE-1:0][DATAWIDTH-1:0] in_C;
    logic [N_SIZE-1:0][DATAWIDTH-1:0] out;
    logic                             valid_out;
    logic                             align_err;

    // Array side: produces skewed lanes, consumes the aligned row
    modport master (
        output valid_in, in_C,
        input  out, valid_out, align_err
    );

    // Deskew buffer side
    modport slave (
        input  valid_in, in_C,
        output out, valid_out, align_err
    );
endinterface
`default_nettype wire

// File: rtl/deskew_buffer.sv
`default_nettype none
// ============================================================================
// Module      : deskew_buffer
// Description : Realigns the skewed column outputs of a systolic array. Lane j
//               passes through N_SIZE-j register stages so that every lane of
//               a row leaves on the same cycle, qualified by one valid_out.
//               Invalid input slots are zeroed on entry, so bubble rows leave
//               as all-zero rows.
//               Optional feature macro: DESKEW_ALIGN_CHECK_EN enables a
//               sticky align_err flag raised when the last-stage valid bits
//               of the lanes disagree; otherwise align_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module deskew_buffer #(
    parameter int N_SIZE    = 4,
    parameter int DATAWIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    deskew_buffer_if.slave     bus
);

`ifdef DESKEW_ALIGN_CHECK_EN
    localparam bit c_ALL_VBITS = 1'b1;
`else
    localparam bit c_ALL_VBITS = 1'b0;
`endif

    logic [N_SIZE-1:0][DATAWIDTH-1:0] w_last_data;
    logic                             w_tail_vld;
`ifdef DESKEW_ALIGN_CHECK_EN
    logic [N_SIZE-1:0]                w_last_vld;
`endif

    for (genvar j = 0; j < N_SIZE; j++) begin : g_lane
        localparam int c_DEPTH = N_SIZE - j;

        logic [DATAWIDTH-1:0] r_data [c_DEPTH];

        // Data delay line: zero-fill on invalid entry, shift every cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < c_DEPTH; s++) begin
                    r_data[s] <= '0;
                end
            end else begin
                r_data[0] <= bus.valid_in[j] ? bus.in_C[j] : '0;
                for (int s = 1; s < c_DEPTH; s++) begin
                    r_data[s] <= r_data[s-1];
                end
            end
        end

        assign w_last_data[j] = r_data[c_DEPTH-1];

        // Valid bits are only kept where something observes them: the
        // single-stage lane drives valid_out, the others feed the checker.
        if (c_ALL_VBITS || (j == N_SIZE - 1)) begin : g_vbit
            logic [c_DEPTH-1:0] r_vld;

            // Valid-bit delay line running in lockstep with the data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= bus.valid_in[j];
                    for (int s = 1; s < c_DEPTH; s++) begin
                        r_vld[s] <= r_vld[s-1];
                    end
                end
            end

`ifdef DESKEW_ALIGN_CHECK_EN
            assign w_last_vld[j] = r_vld[c_DEPTH-1];
`endif

            if (j == N_SIZE - 1) begin : g_tail
                assign w_tail_vld = r_vld[c_DEPTH-1];
            end
        end
    end

    assign bus.out       = w_last_data;
    assign bus.valid_out = w_tail_vld;

`ifdef DESKEW_ALIGN_CHECK_EN
    logic r_align_err;
    logic w_misaligned;

    // Lanes disagree when some but not all last-stage valids are set
    assign w_misaligned = (|w_last_vld) & ~(&w_last_vld);

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_align_err <= 1'b0;
        end else if (w_misaligned) begin
            r_align_err <= 1'b1;
        end
    end

    assign bus.align_err = r_align_err;
`else
    assign bus.align_err = 1'b0;
`endif

endmodule
`default_nettype wire
